// File: rtl/memory_stage.sv
// ============================================================================
// Module   : memory_stage
// Purpose  : RV32I load/store stage; drives the req/ack data port and the *_mw writeback bundle.
// Revision : 1.0
// ============================================================================
`default_nettype none

module memory_stage #(
  parameter int XLEN      = 32,
  parameter int OPLEN     = 23,
  parameter int LOAD_BIT  = 20,
  parameter int STORE_BIT = 19,
  parameter int FUNCT3_M  = 18,
  parameter int FUNCT3_L  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             phase_memory,
  input  logic             jump_state_em,
  input  logic [OPLEN-1:0] decoded_op_em,
  input  logic [4:0]       rdsel_em,
  input  logic [XLEN-1:0]  next_pc_em,
  input  logic [XLEN-1:0]  alu_out_em,
  input  logic [XLEN-1:0]  rs2data_em,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [XLEN-1:0]  dmem_addr,
  output logic [3:0]       dmem_be,
  output logic [XLEN-1:0]  dmem_wdata,
  input  logic             dmem_ack,
  input  logic [XLEN-1:0]  dmem_rdata,
  output logic             jump_state_mw,
  output logic [OPLEN-1:0] decoded_op_mw,
  output logic [4:0]       rdsel_mw,
  output logic [XLEN-1:0]  next_pc_mw,
  output logic [XLEN-1:0]  alu_out_mw,
  output logic [XLEN-1:0]  mem_out_mw,
  output logic             misalign_mw,
  output logic             stall_memory
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [2:0]      w_funct3;
  logic            w_memop;
  logic            w_misaligned;
  logic            w_start;
  logic            w_issue;
  logic [3:0]      w_be;
  logic [XLEN-1:0] w_wdata;
  logic            r_we;
  logic [3:0]      r_be;

  logic [2:0]      w_funct3_mw;
  logic [7:0]      w_ld_byte;
  logic [15:0]     w_ld_half;
  logic [XLEN-1:0] w_ld_data;

  assign w_funct3     = decoded_op_em[FUNCT3_M:FUNCT3_L];
  assign w_memop      = decoded_op_em[LOAD_BIT] | decoded_op_em[STORE_BIT];
  assign w_misaligned = (w_funct3[1:0] == 2'b11)
                      | ((w_funct3[1:0] == 2'b01) & alu_out_em[0])
                      | ((w_funct3[1:0] == 2'b10) & (alu_out_em[1:0] != 2'b00));
  assign w_start      = (r_state == IDLE) & phase_memory;
  assign w_issue      = w_start & w_memop & ~w_misaligned;

  assign stall_memory = w_issue | (r_state == REQ);
  assign dmem_req     = (r_state == REQ);
  assign dmem_we      = (r_state == REQ) & r_we;
  assign dmem_be      = (r_state == REQ) ? r_be : 4'b0000;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_issue) w_next_state = REQ;
      REQ:     if (dmem_ack) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Stores replicate the operand across all lanes so the byte enables alone pick the target.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = rs2data_em;
    if (decoded_op_em[STORE_BIT]) begin
      case (w_funct3[1:0])
        2'b00: begin
          w_be    = 4'b0001 << alu_out_em[1:0];
          w_wdata = {4{rs2data_em[7:0]}};
        end
        2'b01: begin
          w_be    = 4'b0011 << alu_out_em[1:0];
          w_wdata = {2{rs2data_em[15:0]}};
        end
        default: begin
          w_be    = 4'b1111;
          w_wdata = rs2data_em;
        end
      endcase
    end
  end

  // The captured address and opcode select the lane during REQ.
  assign w_funct3_mw = decoded_op_mw[FUNCT3_M:FUNCT3_L];
  assign w_ld_byte   = dmem_rdata[{alu_out_mw[1:0], 3'b000} +: 8];
  assign w_ld_half   = alu_out_mw[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

  always_comb begin
    w_ld_data = dmem_rdata;
    case (w_funct3_mw[1:0])
      2'b00:   w_ld_data = {{(XLEN-8){~w_funct3_mw[2] & w_ld_byte[7]}}, w_ld_byte};
      2'b01:   w_ld_data = {{(XLEN-16){~w_funct3_mw[2] & w_ld_half[15]}}, w_ld_half};
      default: w_ld_data = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_we          <= 1'b0;
      r_be          <= 4'b0000;
      dmem_addr     <= '0;
      dmem_wdata    <= '0;
      jump_state_mw <= 1'b0;
      decoded_op_mw <= '0;
      rdsel_mw      <= '0;
      next_pc_mw    <= '0;
      alu_out_mw    <= '0;
      mem_out_mw    <= '0;
      misalign_mw   <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_start) begin
        jump_state_mw <= jump_state_em;
        decoded_op_mw <= decoded_op_em;
        rdsel_mw      <= rdsel_em;
        next_pc_mw    <= next_pc_em;
        alu_out_mw    <= alu_out_em;
        misalign_mw   <= w_memop & w_misaligned;
        mem_out_mw    <= '0;
      end
      if (w_issue) begin
        r_we       <= decoded_op_em[STORE_BIT];
        r_be       <= w_be;
        dmem_addr  <= {alu_out_em[XLEN-1:2], 2'b00};
        dmem_wdata <= w_wdata;
      end
      if ((r_state == REQ) && dmem_ack) begin
        mem_out_mw <= decoded_op_mw[LOAD_BIT] ? w_ld_data : '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_memory_stage.sv
// ============================================================================
// Module   : tb_memory_stage
// Purpose  : Directed self-checking bench for memory_stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_memory_stage;

  localparam logic [22:0] C_LOAD  = 23'h1 << 20;
  localparam logic [22:0] C_STORE = 23'h1 << 19;

  logic        clk = 1'b0;
  logic        rst;
  logic        phase_memory;
  logic        jump_state_em;
  logic [22:0] decoded_op_em;
  logic [4:0]  rdsel_em;
  logic [31:0] next_pc_em;
  logic [31:0] alu_out_em;
  logic [31:0] rs2data_em;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        jump_state_mw;
  logic [22:0] decoded_op_mw;
  logic [4:0]  rdsel_mw;
  logic [31:0] next_pc_mw;
  logic [31:0] alu_out_mw;
  logic [31:0] mem_out_mw;
  logic        misalign_mw;
  logic        stall_memory;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk(clk), .rst(rst), .phase_memory(phase_memory),
    .jump_state_em(jump_state_em), .decoded_op_em(decoded_op_em),
    .rdsel_em(rdsel_em), .next_pc_em(next_pc_em), .alu_out_em(alu_out_em),
    .rs2data_em(rs2data_em), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .jump_state_mw(jump_state_mw), .decoded_op_mw(decoded_op_mw),
    .rdsel_mw(rdsel_mw), .next_pc_mw(next_pc_mw), .alu_out_mw(alu_out_mw),
    .mem_out_mw(mem_out_mw), .misalign_mw(misalign_mw),
    .stall_memory(stall_memory)
  );

  function automatic logic [22:0] mkop(input logic [22:0] kind, input logic [2:0] f3);
    return kind | ({20'd0, f3} << 16);
  endfunction

  // Present an op at the negedge with phase_memory high.
  task automatic present(input logic [22:0] op, input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    decoded_op_em = op;
    alu_out_em    = addr;
    rs2data_em    = data;
    rdsel_em      = 5'd7;
    next_pc_em    = addr + 32'd4;
    jump_state_em = 1'b1;
    phase_memory  = 1'b1;
    #1;
  endtask

  task automatic edge_then_settle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; phase_memory = 1'b0; jump_state_em = 1'b0; decoded_op_em = '0;
    rdsel_em = '0; next_pc_em = '0; alu_out_em = '0; rs2data_em = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    total++; if (dmem_req !== 1'b0) $display("FAIL reset_req got=%h exp=0", dmem_req); else pass_cnt++;
    total++; if (alu_out_mw !== 32'h0) $display("FAIL reset_alu got=%h exp=0", alu_out_mw); else pass_cnt++;
    total++; if (stall_memory !== 1'b0) $display("FAIL reset_stall got=%h exp=0", stall_memory); else pass_cnt++;
    total++; if (dmem_be !== 4'h0) $display("FAIL reset_be got=%h exp=0", dmem_be); else pass_cnt++;
  endtask

  task automatic test_passthrough();
    present(23'h000033, 32'h1234, 32'h0);
    total++; if (stall_memory !== 1'b0) $display("FAIL add_stall got=%h exp=0", stall_memory); else pass_cnt++;
    edge_then_settle();
    phase_memory = 1'b0;
    total++; if (alu_out_mw !== 32'h1234) $display("FAIL add_alu got=%h exp=1234", alu_out_mw); else pass_cnt++;
    total++; if (next_pc_mw !== 32'h1238) $display("FAIL add_pc got=%h exp=1238", next_pc_mw); else pass_cnt++;
    total++; if (rdsel_mw !== 5'd7 || jump_state_mw !== 1'b1) $display("FAIL add_rd got=%h/%h exp=7/1", rdsel_mw, jump_state_mw); else pass_cnt++;
    total++; if (dmem_req !== 1'b0 || stall_memory !== 1'b0) $display("FAIL add_req got=%h/%h exp=0/0", dmem_req, stall_memory); else pass_cnt++;
    total++; if (misalign_mw !== 1'b0) $display("FAIL add_misalign got=%h exp=0", misalign_mw); else pass_cnt++;
  endtask

  task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] exp);
    present(mkop(C_LOAD, f3), 32'h103, 32'h0);
    total++; if (stall_memory !== 1'b1) $display("FAIL lb_stall_idle got=%h exp=1", stall_memory); else pass_cnt++;
    edge_then_settle();
    phase_memory = 1'b0;
    total++; if (dmem_req !== 1'b1 || stall_memory !== 1'b1) $display("FAIL lb_req got=%h/%h exp=1/1", dmem_req, stall_memory); else pass_cnt++;
    total++; if (dmem_addr !== 32'h100) $display("FAIL lb_addr got=%h exp=100", dmem_addr); else pass_cnt++;
    total++; if (dmem_be !== 4'hF || dmem_we !== 1'b0) $display("FAIL lb_be_we got=%h/%h exp=f/0", dmem_be, dmem_we); else pass_cnt++;
    dmem_ack = 1'b1; dmem_rdata = 32'h80FF_FF7F;
    edge_then_settle();
    dmem_ack = 1'b0;
    total++; if (mem_out_mw !== exp) $display("FAIL lb_data f3=%0d got=%h exp=%h", f3, mem_out_mw, exp); else pass_cnt++;
    total++; if (stall_memory !== 1'b0 || dmem_req !== 1'b0) $display("FAIL lb_done got=%h/%h exp=0/0", stall_memory, dmem_req); else pass_cnt++;
    edge_then_settle();
    total++; if (mem_out_mw !== exp) $display("FAIL lb_hold got=%h exp=%h", mem_out_mw, exp); else pass_cnt++;
  endtask

  task automatic test_store_half_wait();
    present(mkop(C_STORE, 3'b001), 32'h202, 32'hAAAA_BEEF);
    edge_then_settle();
    phase_memory = 1'b0;
    for (int i = 0; i < 4; i++) begin
      total++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) $display("FAIL sh_req_we cyc=%0d got=%h/%h exp=1/1", i, dmem_req, dmem_we); else pass_cnt++;
      total++; if (dmem_addr !== 32'h200) $display("FAIL sh_addr cyc=%0d got=%h exp=200", i, dmem_addr); else pass_cnt++;
      total++; if (dmem_be !== 4'b1100) $display("FAIL sh_be cyc=%0d got=%b exp=1100", i, dmem_be); else pass_cnt++;
      total++; if (dmem_wdata !== 32'hBEEF_BEEF) $display("FAIL sh_wdata cyc=%0d got=%h exp=beefbeef", i, dmem_wdata); else pass_cnt++;
      total++; if (stall_memory !== 1'b1) $display("FAIL sh_stall cyc=%0d got=%h exp=1", i, stall_memory); else pass_cnt++;
      if (i == 3) dmem_ack = 1'b1;
      edge_then_settle();
    end
    dmem_ack = 1'b0;
    total++; if (dmem_req !== 1'b0 || dmem_be !== 4'h0 || dmem_we !== 1'b0) $display("FAIL sh_done got=%h/%h/%h exp=0/0/0", dmem_req, dmem_be, dmem_we); else pass_cnt++;
    total++; if (mem_out_mw !== 32'h0) $display("FAIL sh_memout got=%h exp=0", mem_out_mw); else pass_cnt++;
    edge_then_settle();
  endtask

  task automatic test_misaligned();
    present(mkop(C_LOAD, 3'b010), 32'h101, 32'h0);
    total++; if (stall_memory !== 1'b0) $display("FAIL lw_mis_stall got=%h exp=0", stall_memory); else pass_cnt++;
    edge_then_settle();
    phase_memory = 1'b0;
    total++; if (misalign_mw !== 1'b1) $display("FAIL lw_misalign got=%h exp=1", misalign_mw); else pass_cnt++;
    total++; if (dmem_req !== 1'b0 || stall_memory !== 1'b0) $display("FAIL lw_mis_req got=%h/%h exp=0/0", dmem_req, stall_memory); else pass_cnt++;
    edge_then_settle();
    total++; if (dmem_req !== 1'b0) $display("FAIL lw_mis_req2 got=%h exp=0", dmem_req); else pass_cnt++;
  endtask

  task automatic test_reset_mid_req();
    present(mkop(C_LOAD, 3'b001), 32'h2, 32'h0);
    edge_then_settle();
    phase_memory = 1'b0;
    total++; if (dmem_req !== 1'b1) $display("FAIL lh_rst_pre got=%h exp=1", dmem_req); else pass_cnt++;
    rst = 1'b1;
    edge_then_settle();
    rst = 1'b0;
    total++; if (dmem_req !== 1'b0 || stall_memory !== 1'b0) $display("FAIL rst_req got=%h/%h exp=0/0", dmem_req, stall_memory); else pass_cnt++;
    total++; if (alu_out_mw !== 32'h0 || decoded_op_mw !== 23'h0 || misalign_mw !== 1'b0) $display("FAIL rst_mw got=%h/%h/%h exp=0/0/0", alu_out_mw, decoded_op_mw, misalign_mw); else pass_cnt++;
    dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
    edge_then_settle();
    dmem_ack = 1'b0;
    total++; if (mem_out_mw !== 32'h0 || dmem_req !== 1'b0) $display("FAIL rst_late_ack got=%h/%h exp=0/0", mem_out_mw, dmem_req); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    present(mkop(C_STORE, 3'b010), 32'h10, 32'h1234_5678);
    edge_then_settle();
    total++; if (dmem_be !== 4'hF || dmem_wdata !== 32'h1234_5678) $display("FAIL sw_lane got=%h/%h exp=f/12345678", dmem_be, dmem_wdata); else pass_cnt++;
    dmem_ack = 1'b1;
    decoded_op_em = mkop(C_LOAD, 3'b101);
    alu_out_em    = 32'h6;
    edge_then_settle();
    dmem_ack = 1'b0;
    total++; if (dmem_req !== 1'b0 || stall_memory !== 1'b0) $display("FAIL b2b_done got=%h/%h exp=0/0", dmem_req, stall_memory); else pass_cnt++;
    total++; if (alu_out_mw !== 32'h10) $display("FAIL b2b_hold_alu got=%h exp=10", alu_out_mw); else pass_cnt++;
    edge_then_settle();
    total++; if (dmem_req !== 1'b0 || stall_memory !== 1'b1) $display("FAIL b2b_idle got=%h/%h exp=0/1", dmem_req, stall_memory); else pass_cnt++;
    edge_then_settle();
    phase_memory = 1'b0;
    total++; if (dmem_req !== 1'b1 || dmem_addr !== 32'h4 || dmem_we !== 1'b0) $display("FAIL b2b_issue got=%h/%h/%h exp=1/4/0", dmem_req, dmem_addr, dmem_we); else pass_cnt++;
    dmem_ack = 1'b1; dmem_rdata = 32'h8001_0000;
    edge_then_settle();
    dmem_ack = 1'b0;
    total++; if (mem_out_mw !== 32'h0000_8001) $display("FAIL b2b_lhu got=%h exp=00008001", mem_out_mw); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load_byte(3'b000, 32'hFFFF_FF80);
    test_load_byte(3'b100, 32'h0000_0080);
    test_store_half_wait();
    test_misaligned();
    test_reset_mid_req();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/memory_stage.md
Name: memory_stage

Overview:
Memory stage of the RockWave core, directly upstream of writeback. Captures execute-stage results, performs RV32I loads/stores (LB/LH/LW/LBU/LHU, SB/SH/SW) over a req/ack data-memory port, aligns and extends load data, and drives the *_mw bundle consumed by writeback. Raises stall_memory to the state machine while a bus access is outstanding.

Parameters:
XLEN, 32, datapath width
OPLEN, 23, decoded-opcode width
LOAD_BIT, 20, decoded_op bit: op is a load
STORE_BIT, 19, decoded_op bit: op is a store
FUNCT3_M, 18, decoded_op MSB of funct3 field
FUNCT3_L, 16, decoded_op LSB of funct3 field

Ports:
clk  in  1  core clock
rst  in  1  synchronous reset, active-high
phase_memory  in  1  memory phase from state machine
jump_state_em  in  1  jump flag from execute
decoded_op_em  in  OPLEN  decoded opcode
rdsel_em  in  5  destination register
next_pc_em  in  XLEN  next PC
alu_out_em  in  XLEN  ALU result / effective address
rs2data_em  in  XLEN  store data
dmem_req  out  1  bus request
dmem_we  out  1  1=write
dmem_addr  out  XLEN  word address, bits[1:0]=0
dmem_be  out  4  byte enables
dmem_wdata  out  XLEN  lane-shifted store data
dmem_ack  in  1  bus accept/complete
dmem_rdata  in  XLEN  read word, valid with ack
jump_state_mw, decoded_op_mw, rdsel_mw, next_pc_mw, alu_out_mw  out  1/OPLEN/5/XLEN/XLEN  registered pass-through
mem_out_mw  out  XLEN  aligned, extended load data
misalign_mw  out  1  access misaligned, not issued
stall_memory  out  1  stall request to state machine

Behaviour:
- One clock (clk); synchronous active-high reset (rst). Reset: all outputs and registers 0, state IDLE.
- States IDLE, REQ, DONE. memop = LOAD_BIT|STORE_BIT; size from funct3[1:0]: 00 byte, 01 half, 10 word; funct3[2]=1 zero-extend.
- Misaligned: half with addr[0]=1, word with addr[1:0]!=0, or funct3[1:0]=11.
- IDLE & phase_memory (cycle N): all *_mw pass-through registers load at edge of N; misalign_mw <= memop & misaligned. If memop & aligned -> REQ, else stay IDLE, mem_out_mw <= 0.
- stall_memory (comb) = (IDLE & phase_memory & memop & aligned) | REQ. Low in DONE and for non-mem/misaligned ops (zero-latency pass-through).
- REQ: dmem_req=1, address/we/be/wdata registered at entry and held stable until ack. dmem_ack sampled only in REQ; ack in first REQ cycle allowed (1-cycle access). On ack -> DONE; load: mem_out_mw <= extracted data; store: mem_out_mw <= 0.
- Store lanes: SB be=0001<<addr[1:0], wdata=byte replicated x4; SH be=0011<<addr[1:0], wdata=half replicated x2; SW be=1111.
- Load extract: byte = rdata[8*addr[1:0]+:8], half = rdata[16*addr[1]+:16]; sign- or zero-extend to XLEN.
- Load: dmem_we=0, be=1111. dmem_req=0 and be/we held 0 outside REQ.
- DONE: one cycle, outputs valid, stall low -> IDLE. phase_memory ignored in REQ and DONE.
- Outputs hold until next capture. Reset mid-REQ: request dropped at that edge, no ack consumed afterward.

Test Plan:
- ADD-type op, alu_out_em=0x1234, phase_memory 1 cycle -> alu_out_mw=0x1234 next cycle, stall_memory never high, dmem_req never high.
- LB addr 0x103, rdata=0x80FF_FF7F on first REQ cycle -> mem_out_mw=0xFFFF_FF80 in DONE; LBU -> 0x0000_0080; stall high 2 cycles.
- SH addr 0x202, rs2data=0xAAAA_BEEF, ack delayed 3 cycles -> dmem_addr=0x200, be=1100, wdata=0xBEEF_BEEF, we=1, all stable 4 REQ cycles.
- LW addr 0x101 -> misalign_mw=1, dmem_req never asserted, stall_memory low.
- LH addr 0x2 pending in REQ, rst=1 for one cycle -> next cycle req=0, state IDLE, all outputs 0; late ack ignored.
- Back-to-back: SW then LHU addr 0x6, rdata=0x8001_0000 -> second access issues only after DONE; mem_out_mw=0x0000_8001.
